// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt source controller: sticky status, enable mask, registered IRQ vector (optional FORCE register under INTR_CTRL_FORCE_EN)
module intr_ctrl #(
    parameter int N_IRQ  = 64,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       evt,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [63:0]       rd_data,
    output logic              rd_valid,
    output logic [63:0]       IRQ,
    output logic              irq_any
);

    // Sources at or above N_IRQ are tied off everywhere through this mask.
    localparam logic [63:0] VALID_MASK = {64{1'b1}} >> (64 - N_IRQ);

    localparam logic [31:0] A_STATUS  = 32'd0;
    localparam logic [31:0] A_ENABLE  = 32'd1;
    localparam logic [31:0] A_MODE    = 32'd2;
    localparam logic [31:0] A_PENDING = 32'd3;
    localparam logic [31:0] A_FORCE   = 32'd4;

    logic [63:0] status_q, status_d;
    logic [63:0] enable_q, enable_d;
    logic [63:0] mode_q, mode_d;
    logic [63:0] evt_q, evt_d;
    logic [63:0] irq_q, irq_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        irq_any_q, irq_any_d;
    logic        rd_valid_q, rd_valid_d;

    logic [31:0] wa;
    logic [31:0] ra;
    logic [63:0] force_vec;
    logic [63:0] set_vec;
    logic [63:0] clr_vec;

    assign wa = 32'(wr_addr);
    assign ra = 32'(rd_addr);

`ifdef INTR_CTRL_FORCE_EN
    // FORCE writes set STATUS bits through the same path as events.
    assign force_vec = (wr_en && (wa == A_FORCE)) ? wr_data : 64'd0;
`else
    assign force_vec = 64'd0;
`endif

    // Set sources: rising edge or level per MODE bit, plus FORCE; clear is W1C on STATUS.
    always_comb begin
        set_vec = ((mode_q & evt) | (~mode_q & evt & ~evt_q) | force_vec) & VALID_MASK;
        clr_vec = (wr_en && (wa == A_STATUS)) ? wr_data : 64'd0;
    end

    // Next-state for register file, IRQ pipeline and read port; reads see pre-write values.
    always_comb begin
        status_d   = ((status_q & ~clr_vec) | set_vec) & VALID_MASK;
        enable_d   = enable_q;
        mode_d     = mode_q;
        evt_d      = evt & VALID_MASK;
        irq_d      = status_q & enable_q;
        irq_any_d  = |irq_d;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;

        if (wr_en && (wa == A_ENABLE)) enable_d = wr_data & VALID_MASK;
        if (wr_en && (wa == A_MODE))   mode_d   = wr_data & VALID_MASK;

        if (rd_en) begin
            case (ra)
                A_STATUS:  rd_data_d = status_q;
                A_ENABLE:  rd_data_d = enable_q;
                A_MODE:    rd_data_d = mode_q;
                A_PENDING: rd_data_d = status_q & enable_q;
                default:   rd_data_d = 64'd0;
            endcase
        end
    end

    // State registers with asynchronous clear so IRQ drops as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= 64'd0;
            enable_q   <= 64'd0;
            mode_q     <= 64'd0;
            evt_q      <= 64'd0;
            irq_q      <= 64'd0;
            irq_any_q  <= 1'b0;
            rd_data_q  <= 64'd0;
            rd_valid_q <= 1'b0;
        end else begin
            status_q   <= status_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            evt_q      <= evt_d;
            irq_q      <= irq_d;
            irq_any_q  <= irq_any_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign IRQ      = irq_q;
    assign irq_any  = irq_any_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
